// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 4-bit CPU.
// Owns the program counter, fetches instructions over a req/ack handshake and
// walks each one through fetch, decode, execute and writeback. The write
// enable is a single-cycle pulse in writeback. Halt and fetch-timeout fault
// are sticky until reset.
module cpu_sequencer #(
    parameter int unsigned PC_W       = 4,
    parameter logic [7:0]  HALT_INSTR = 8'hFF,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [2:0]      alu_op,
    output logic [1:0]      dest_reg,
    output logic [1:0]      source_reg,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            fault
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Last no-ack FETCH cycle index before faulting; unused when TIMEOUT is 0.
    localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalted,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            step_mode_q, step_mode_d;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            ir_q        <= 8'h00;
            cnt_q       <= '0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            step_mode_q <= step_mode_d;
        end
    end

    // Next-state, instruction capture, wait counting and pc advance.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        cnt_d       = '0;
        step_mode_d = step_mode_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d     = StFetch;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = StFetch;
                    step_mode_d = 1'b1;
                end
            end
            StFetch: begin
                // An ack on the timeout cycle still wins.
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = StDecode;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDecode: begin
                state_d = (ir_q == HALT_INSTR) ? StHalted : StExecute;
            end
            StExecute: begin
                state_d = StWriteback;
            end
            StWriteback: begin
                pc_d        = pc_q + PC_W'(1);
                step_mode_d = 1'b0;
                state_d     = (run && !step_mode_q) ? StFetch : StIdle;
            end
            StHalted: begin
                state_d = StHalted;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state and ir only.
    always_comb begin
        imem_req   = (state_q == StFetch);
        imem_addr  = pc_q;
        reg_we     = (state_q == StWriteback);
        halted     = (state_q == StHalted);
        fault      = (state_q == StFault);
        pc         = pc_q;
        alu_op     = ir_q[7:5];
        dest_reg   = ir_q[4:3];
        source_reg = ir_q[2:1];
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a small instruction
// memory model whose ack latency can be set or disabled.
module tb_cpu_sequencer;

    localparam int unsigned PC_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic            step;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;
    logic [2:0]      alu_op;
    logic [1:0]      dest_reg;
    logic [1:0]      source_reg;
    logic            reg_we;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16];
    int         ack_delay = 0;
    bit         mem_on    = 1'b1;
    int         wait_n    = 0;
    int         we_cnt;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .PC_W       (PC_W),
        .HALT_INSTR (8'hFF),
        .TIMEOUT    (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_op     (alu_op),
        .dest_reg   (dest_reg),
        .source_reg (source_reg),
        .reg_we     (reg_we),
        .pc         (pc),
        .halted     (halted),
        .fault      (fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Memory responder: acks after ack_delay request cycles.
    initial begin
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req && mem_on) begin
                if (wait_n == ack_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    wait_n    = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_n++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_n   = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h4A;
        mem[1] = 8'h23;

        // Reset state
        do_reset();
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_we", reg_we, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_ctrl", {alu_op, dest_reg, source_reg}, 0);

        // Zero-wait run, then run dropped mid-instruction
        run = 1'b1;
        tick();
        check_eq("t1_req", imem_req, 1);
        check_eq("t1_addr", imem_addr, 0);
        check_eq("t1_we_fetch", reg_we, 0);
        tick();
        check_eq("t1_req_drop", imem_req, 0);
        check_eq("t1_alu_op", alu_op, 3'b010);
        check_eq("t1_dest", dest_reg, 2'b01);
        check_eq("t1_src", source_reg, 2'b01);
        tick();
        check_eq("t1_we_exec", reg_we, 0);
        tick();
        check_eq("t1_we_wb", reg_we, 1);
        check_eq("t1_pc_wb", pc, 0);
        tick();
        check_eq("t1_we_after", reg_we, 0);
        check_eq("t1_pc", pc, 1);
        check_eq("t1_req2", imem_req, 1);
        check_eq("t1_addr2", imem_addr, 1);
        run = 1'b0;
        tick();
        check_eq("t1_ctrl2", {alu_op, dest_reg, source_reg}, {3'b001, 2'b00, 2'b01});
        tick();
        tick();
        check_eq("t1_we2", reg_we, 1);
        tick();
        check_eq("t1_idle_req", imem_req, 0);
        check_eq("t1_idle_pc", pc, 2);
        tick();
        check_eq("t1_idle_stay", imem_req, 0);

        // Three wait cycles
        do_reset();
        check_eq("t2_rst_ctrl", {alu_op, dest_reg, source_reg}, 0);
        check_eq("t2_rst_pc", pc, 0);
        ack_delay = 3;
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t2_req_hold", imem_req, 1);
            check_eq("t2_addr_hold", imem_addr, 0);
        end
        tick();
        check_eq("t2_req_drop", imem_req, 0);
        run = 1'b0;
        tick();
        check_eq("t2_we_exec", reg_we, 0);
        tick();
        check_eq("t2_we_wb", reg_we, 1);
        tick();
        check_eq("t2_pc", pc, 1);
        check_eq("t2_idle", imem_req, 0);
        ack_delay = 0;

        // Single step; step held into FETCH must not start another
        do_reset();
        step = 1'b1;
        tick();
        check_eq("t3_req", imem_req, 1);
        tick();
        step = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            we_cnt += int'(reg_we);
        end
        check_eq("t3_we_count", we_cnt, 1);
        check_eq("t3_pc", pc, 1);
        check_eq("t3_idle", imem_req, 0);

        // pc wraps from 15 to 0
        mem[1] = 8'h4A;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 100 && pc != 4'd15; i++) tick();
        check_eq("t4_reach15", pc, 15);
        for (int i = 0; i < 10 && !reg_we; i++) tick();
        check_eq("t4_we", reg_we, 1);
        check_eq("t4_pc_wb", pc, 15);
        tick();
        check_eq("t4_pc_wrap", pc, 0);
        check_eq("t4_req", imem_req, 1);
        check_eq("t4_addr", imem_addr, 0);

        // Halt instruction at address 1
        mem[1] = 8'hFF;
        do_reset();
        run = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 20 && !halted; i++) begin
            tick();
            we_cnt += int'(reg_we);
        end
        check_eq("t5_halted", halted, 1);
        check_eq("t5_pc", pc, 1);
        check_eq("t5_we_count", we_cnt, 1);
        check_eq("t5_req", imem_req, 0);
        step = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            we_cnt += int'(reg_we) + int'(imem_req);
        end
        check_eq("t5_sticky", halted, 1);
        check_eq("t5_quiet", we_cnt, 0);
        rst = 1'b1;
        run = 1'b0;
        step = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("t5_rst_halted", halted, 0);
        check_eq("t5_rst_pc", pc, 0);
        tick();
        check_eq("t5_idle", imem_req, 0);
        mem[1] = 8'h4A;

        // Fetch timeout
        mem_on = 1'b0;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check_eq("t6_no_fault_15", fault, 0);
        check_eq("t6_req_15", imem_req, 1);
        tick();
        check_eq("t6_fault", fault, 1);
        check_eq("t6_req_off", imem_req, 0);
        step = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("t6_sticky", fault, 1);
        check_eq("t6_sticky_req", {imem_req, reg_we, halted}, 0);

        // Ack on the 15th cycle beats the timeout
        mem_on = 1'b1;
        ack_delay = 14;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check_eq("t6b_req_15", imem_req, 1);
        tick();
        check_eq("t6b_no_fault", fault, 0);
        check_eq("t6b_decode", imem_req, 0);
        run = 1'b0;
        tick();
        tick();
        check_eq("t6b_we", reg_we, 1);
        check_eq("t6b_fault_end", fault, 0);
        ack_delay = 0;

        // Reset during FETCH drops req
        mem_on = 1'b0;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        check_eq("t6c_req", imem_req, 1);
        rst = 1'b1;
        tick();
        check_eq("t6c_req_rst", imem_req, 0);
        check_eq("t6c_fault_rst", fault, 0);
        rst = 1'b0;
        run = 1'b0;
        tick();
        check_eq("t6c_idle", imem_req, 0);
        mem_on = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
